// File: rtl/block_lock_sync.sv
// Purpose : 64b/66b receive-lane sync-header lock; acquires/holds block lock, requests gearbox slips.
// Latency : 1 cycle block_in -> block_out; lock decisions take effect on the edge after the tested block.
// Backpr. : none; block_in_valid=0 cycles are ignored and freeze all lock state, no ready is returned.
//
// Ports:
//   RX_CLK          receive clock, all outputs registered on its rising edge
//   reset           asynchronous active-low reset
//   block_in        66-bit block from gearbox, sync header in [65:64]
//   block_in_valid  block_in carries a new block
//   block_out       registered copy of block_in
//   block_out_valid block_out valid and lane locked
//   block_lock      lane holds sync-header lock
//   slip            one-cycle bit-slip request to the gearbox
//   lock_loss_count saturating count of lock->unlock transitions
module block_lock_sync #(
    parameter int LOCK_CNT   = 64,
    parameter int WINDOW     = 1024,
    parameter int INVLD_MAX  = 65,
    parameter int SLIP_GUARD = 4
) (
    input  logic        RX_CLK,
    input  logic        reset,
    input  logic [65:0] block_in,
    input  logic        block_in_valid,
    output logic [65:0] block_out,
    output logic        block_out_valid,
    output logic        block_lock,
    output logic        slip,
    output logic [15:0] lock_loss_count
);

    localparam int GW = $clog2(SLIP_GUARD + 1);

    localparam logic [10:0]   LOCK_CNT_C  = 11'(LOCK_CNT);
    localparam logic [10:0]   WINDOW_C    = 11'(WINDOW);
    localparam logic [6:0]    INVLD_MAX_C = 7'(INVLD_MAX);
    // SLIP_WAIT counts down to zero inclusive, so load one less than the guard length.
    localparam logic [GW-1:0] GUARD_LOAD  = GW'(SLIP_GUARD - 1);
    localparam logic [GW-1:0] GUARD_ONE   = GW'(1);

    typedef enum logic [1:0] {
        LOCK_INIT = 2'd0,
        TEST      = 2'd1,
        SLIP      = 2'd2,
        SLIP_WAIT = 2'd3
    } state_t;

    state_t          state_q;
    logic [10:0]     sh_cnt_q;
    logic [6:0]      invld_cnt_q;
    logic [GW-1:0]   guard_q;
    logic [65:0]     block_out_q;
    logic            block_out_valid_q;
    logic            block_lock_q;
    logic            slip_q;
    logic [15:0]     lock_loss_count_q;

    logic            sh_valid;
    logic [10:0]     sh_cnt_d;
    logic [6:0]      invld_cnt_d;

    // Only 01 and 10 are legal sync headers.
    assign sh_valid    = block_in[65] ^ block_in[64];
    // Counter values as they would be after counting the block presented this cycle.
    assign sh_cnt_d    = sh_cnt_q + 11'd1;
    assign invld_cnt_d = invld_cnt_q + {6'd0, ~sh_valid};

    always_ff @(posedge RX_CLK or negedge reset) begin
        if (!reset) begin
            state_q           <= LOCK_INIT;
            sh_cnt_q          <= '0;
            invld_cnt_q       <= '0;
            guard_q           <= '0;
            block_out_q       <= '0;
            block_out_valid_q <= 1'b0;
            block_lock_q      <= 1'b0;
            slip_q            <= 1'b0;
            lock_loss_count_q <= '0;
        end else begin
            block_out_q       <= block_in;
            // Qualified with the lock held before this edge's decision.
            block_out_valid_q <= block_in_valid & block_lock_q;
            slip_q            <= 1'b0;

            case (state_q)
                LOCK_INIT: begin
                    sh_cnt_q    <= '0;
                    invld_cnt_q <= '0;
                    state_q     <= TEST;
                end

                TEST: begin
                    if (block_in_valid) begin
                        if (!block_lock_q) begin
                            if (!sh_valid) begin
                                state_q <= SLIP;
                                slip_q  <= 1'b1;
                            end else if (sh_cnt_d == LOCK_CNT_C) begin
                                block_lock_q <= 1'b1;
                                sh_cnt_q     <= '0;
                                invld_cnt_q  <= '0;
                            end else begin
                                sh_cnt_q <= sh_cnt_d;
                            end
                        end else begin
                            // Loss of lock is checked first so it beats a coincident window end.
                            if (invld_cnt_d == INVLD_MAX_C) begin
                                block_lock_q <= 1'b0;
                                state_q      <= SLIP;
                                slip_q       <= 1'b1;
                                if (lock_loss_count_q != 16'hFFFF) begin
                                    lock_loss_count_q <= lock_loss_count_q + 16'd1;
                                end
                            end else if (sh_cnt_d == WINDOW_C) begin
                                sh_cnt_q    <= '0;
                                invld_cnt_q <= '0;
                            end else begin
                                sh_cnt_q    <= sh_cnt_d;
                                invld_cnt_q <= invld_cnt_d;
                            end
                        end
                    end
                end

                SLIP: begin
                    block_lock_q <= 1'b0;
                    guard_q      <= GUARD_LOAD;
                    state_q      <= SLIP_WAIT;
                end

                SLIP_WAIT: begin
                    if (guard_q == '0) begin
                        state_q <= LOCK_INIT;
                    end else begin
                        guard_q <= guard_q - GUARD_ONE;
                    end
                end

                default: state_q <= LOCK_INIT;
            endcase
        end
    end

    assign block_out       = block_out_q;
    assign block_out_valid = block_out_valid_q;
    assign block_lock      = block_lock_q;
    assign slip            = slip_q;
    assign lock_loss_count = lock_loss_count_q;

endmodule

// File: tb/tb_block_lock_sync.sv
// Directed bench for block_lock_sync: acquisition, slip/guard, windowed loss of lock,
// idle-cycle freezing and asynchronous reset, checked with immediate assertions.
module tb_block_lock_sync;

    logic        RX_CLK;
    logic        reset;
    logic [65:0] block_in;
    logic        block_in_valid;
    logic [65:0] block_out;
    logic        block_out_valid;
    logic        block_lock;
    logic        slip;
    logic [15:0] lock_loss_count;

    int checks = 0;
    int errors = 0;
    logic model_lock = 1'b0;

    block_lock_sync dut (
        .RX_CLK          (RX_CLK),
        .reset           (reset),
        .block_in        (block_in),
        .block_in_valid  (block_in_valid),
        .block_out       (block_out),
        .block_out_valid (block_out_valid),
        .block_lock      (block_lock),
        .slip            (slip),
        .lock_loss_count (lock_loss_count)
    );

    initial RX_CLK = 1'b0;
    always #5 RX_CLK = ~RX_CLK;

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one block for one edge, then check the registered outputs #1 after the edge.
    // nl/ns: lock and slip expected after this edge.
    task automatic drive(input logic [1:0] h, input logic v, input logic nl, input logic ns);
        logic [65:0] blk;
        logic        exp_bov;
        blk            = {h, $urandom, $urandom};
        block_in       = blk;
        block_in_valid = v;
        exp_bov        = v & model_lock;
        @(posedge RX_CLK);
        #1;
        check("block_out", block_out, blk);
        check("block_out_valid", {65'd0, block_out_valid}, {65'd0, exp_bov});
        check("block_lock", {65'd0, block_lock}, {65'd0, nl});
        check("slip", {65'd0, slip}, {65'd0, ns});
        model_lock = nl;
    endtask

    // Cycles after a slip pulse during which input is ignored: SLIP, 4 x SLIP_WAIT, LOCK_INIT.
    // Invalid headers are driven to prove they are not sampled.
    task automatic guard_cycles();
        for (int i = 0; i < 6; i++) drive(2'b11, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic acquire();
        for (int i = 0; i < 63; i++) drive(2'b01, 1'b1, 1'b0, 1'b0);
        drive(2'b10, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_lock"}, {65'd0, block_lock}, 66'd0);
        check({tag, "_slip"}, {65'd0, slip}, 66'd0);
        check({tag, "_bov"}, {65'd0, block_out_valid}, 66'd0);
        check({tag, "_bout"}, block_out, 66'd0);
        check({tag, "_llc"}, {50'd0, lock_loss_count}, 66'd0);
    endtask

    initial begin
        // 1: reset for 3 cycles, acquire with 64 good headers.
        reset          = 1'b0;
        block_in       = '0;
        block_in_valid = 1'b0;
        repeat (3) @(posedge RX_CLK);
        #1;
        check_zero_outputs("reset");
        reset = 1'b1;
        drive(2'b01, 1'b0, 1'b0, 1'b0);         // LOCK_INIT cycle
        acquire();
        drive(2'b01, 1'b1, 1'b1, 1'b0);         // first block_out_valid
        check("llc_after_acq", {50'd0, lock_loss_count}, 66'd0);

        // 2: bad header on the 10th block while unlocked.
        #3;
        reset = 1'b0;
        #1;
        check_zero_outputs("async_rst_locked");
        @(posedge RX_CLK);
        #1;
        reset      = 1'b1;
        model_lock = 1'b0;
        drive(2'b01, 1'b0, 1'b0, 1'b0);         // LOCK_INIT cycle
        for (int i = 0; i < 9; i++) drive(2'b01, 1'b1, 1'b0, 1'b0);
        drive(2'b00, 1'b1, 1'b0, 1'b1);
        guard_cycles();
        acquire();

        // 3: two windows each with 64 invalid headers keep lock.
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 1024; i++) begin
                drive(((i % 16) == 5) ? 2'b00 : 2'b01, 1'b1, 1'b1, 1'b0);
            end
        end
        check("llc_two_windows", {50'd0, lock_loss_count}, 66'd0);

        // 4: 65 invalid headers in one window (65th at block 512) lose lock.
        for (int i = 0; i <= 512; i++) begin
            drive(((i % 8) == 0) ? 2'b11 : 2'b10, 1'b1, (i != 512), (i == 512));
        end
        check("llc_loss1", {50'd0, lock_loss_count}, 66'd1);
        guard_cycles();
        acquire();

        // 5: 65th invalid header on the 1024th block of the window.
        for (int i = 0; i < 1024; i++) begin
            drive((i < 64 || i == 1023) ? 2'b00 : 2'b01, 1'b1, (i != 1023), (i == 1023));
        end
        check("llc_loss2", {50'd0, lock_loss_count}, 66'd2);
        guard_cycles();
        acquire();

        // 6: idle cycles freeze both counters; idle blocks carry bad headers.
        for (int k = 0; k < 64; k++) begin
            drive(2'b00, 1'b1, 1'b1, 1'b0);
            repeat ($urandom_range(0, 3)) drive(2'b00, 1'b0, 1'b1, 1'b0);
        end
        for (int k = 0; k < 959; k++) begin
            drive(2'b01, 1'b1, 1'b1, 1'b0);
            if ((k % 7) == 0) drive(2'b11, 1'b0, 1'b1, 1'b0);
        end
        // 1024th tested block is the 65th invalid one.
        drive(2'b00, 1'b1, 1'b0, 1'b1);
        check("llc_loss3", {50'd0, lock_loss_count}, 66'd3);
        guard_cycles();
        acquire();
        for (int i = 0; i < 10; i++) drive(2'b01, 1'b1, 1'b1, 1'b0);
        check("bov_before_rst", {65'd0, block_out_valid}, 66'd1);

        // Reset mid-window, checked before the next edge.
        #3;
        reset = 1'b0;
        #1;
        check_zero_outputs("async_rst_window");
        @(posedge RX_CLK);
        #1;
        reset = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
